// File: rtl/spi_txn_arbiter.sv
// -----------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one SPI controller engine among NUM_REQ on-chip requesters. A
// round-robin pointer picks the next owner among the asserted requests. The
// owner's length and write word are latched and handed to the engine with a
// one-cycle start pulse. The block then waits for the engine's done pulse,
// with a timeout guard, and returns the read word plus a one-hot acknowledge
// to the owner.
//
// Ports
//   axi_clk     sole clock
//   axi_resetn  asynchronous active-low reset
//   req         per-requester request level
//   req_len     per-requester bit count, requester i at [i*LEN_W +: LEN_W]
//   req_wdata   per-requester write word, requester i at [i*DATA_W +: DATA_W]
//   ack         one-hot completion pulse to the owning requester
//   rdata       read-back word, valid in the ack cycle, held afterwards
//   err         timeout or illegal length, valid in the ack cycle
//   busy        high from grant until ack, inclusive
//   grant_id    index of the current or last owner
//   spi_start   one-cycle start pulse to the engine
//   spi_len     latched bit count presented to the engine
//   spi_wdata   latched write word presented to the engine
//   spi_done    one-cycle completion pulse from the engine
//   spi_rdata   engine read word, valid with spi_done
// -----------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       axi_clk,
    input  logic                       axi_resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       spi_start,
    output logic [LEN_W-1:0]           spi_len,
    output logic [DATA_W-1:0]          spi_wdata,
    input  logic                       spi_done,
    input  logic [DATA_W-1:0]          spi_rdata
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0]   LAST_ID  = IDW'(NUM_REQ - 1);
    localparam logic [31:0]      MAX_LEN  = 32'(DATA_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              busy_q,      busy_d;
    logic [IDW-1:0]    grant_id_q,  grant_id_d;
    logic [IDW-1:0]    rr_ptr_q,    rr_ptr_d;
    logic              spi_start_q, spi_start_d;
    logic [LEN_W-1:0]  spi_len_q,   spi_len_d;
    logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
    logic [NUM_REQ-1:0] ack_q,      ack_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

    // Per-requester views of the flattened request buses.
    logic [LEN_W-1:0]   len_arr   [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_onehot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign len_arr[gi]      = req_len[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi]    = req_wdata[gi*DATA_W +: DATA_W];
            assign owner_onehot[gi] = (grant_id_q == IDW'(gi));
        end
    endgenerate

    // A length of zero or wider than the shift register cannot be run.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && ({{(32-LEN_W){1'b0}}, len} <= MAX_LEN);
    endfunction

    // Round-robin search: first asserted request at or above rr_ptr,
    // wrapping modulo NUM_REQ. One extra bit on the candidate keeps the
    // sum from overflowing before the wrap subtraction.
    logic           found;
    logic [IDW-1:0] sel_idx;
    logic [IDW:0]   cand;

    always_comb begin
        found   = 1'b0;
        sel_idx = rr_ptr_q;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        spi_start_d = 1'b0;
        spi_len_d   = spi_len_q;
        spi_wdata_d = spi_wdata_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_ISSUE;
                    busy_d      = 1'b1;
                    grant_id_d  = sel_idx;
                    spi_len_d   = len_arr[sel_idx];
                    spi_wdata_d = wdata_arr[sel_idx];
                    // Registered so the pulse lines up with the ISSUE cycle.
                    spi_start_d = len_legal(len_arr[sel_idx]);
                end
            end
            S_ISSUE: begin
                if (len_legal(spi_len_q)) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    ack_d   = owner_onehot;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                // Done is tested first so it wins over a coincident expiry.
                if (spi_done) begin
                    rdata_d = spi_rdata;
                    err_d   = 1'b0;
                    ack_d   = owner_onehot;
                    state_d = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = owner_onehot;
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                busy_d   = 1'b0;
                rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            spi_start_q <= 1'b0;
            spi_len_q   <= '0;
            spi_wdata_q <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            spi_start_q <= spi_start_d;
            spi_len_q   <= spi_len_d;
            spi_wdata_q <= spi_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign spi_start = spi_start_q;
    assign spi_len   = spi_len_q;
    assign spi_wdata = spi_wdata_q;

endmodule
